// File: rtl/score_tracker.sv
// -----------------------------------------------------------------------------
// score_tracker
//
// Keeps the game-event state that feeds the face-display controller. It counts
// points in packed BCD, tracks the remaining lives for the current game, keeps
// the best score of the session, and raises one-cycle event pulses for a lost
// life (died) and for a new session best (newHighScore).
//
// Parameters
//   DIGITS     number of BCD digits in score / high_score (1..4)
//   MAX_LIVES  lives granted at game start (1..7)
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset, aborts any game
//   game_start    in   pulse: start or restart a game
//   point         in   pulse: score +1 (saturates at all-9s)
//   hit           in   pulse: lose one life
//   score         out  current score, packed BCD, MS digit on top
//   high_score    out  session best, packed BCD
//   lives         out  remaining lives, binary
//   game_active   out  high while a game is being played
//   newHighScore  out  pulse: the game just ended above the previous best
//   died          out  pulse: a life was lost
//
// Optional build macro
//   SCORE_TRACKER_EXTRA_LIFE_EN  a point that rolls the ones digit from 9 to 0
//                                grants one extra life, capped at MAX_LIVES.
// -----------------------------------------------------------------------------
module score_tracker #(
  parameter int DIGITS    = 2,
  parameter int MAX_LIVES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_start,
  input  logic                  point,
  input  logic                  hit,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic [2:0]            lives,
  output logic                  game_active,
  output logic                  newHighScore,
  output logic                  died
);

  localparam int                SW      = 4 * DIGITS;
  localparam logic [SW-1:0]     ALL9    = {DIGITS{4'h9}};
  localparam logic [2:0]        LIVES_0 = 3'(MAX_LIVES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t state;

  // Set in the CHECK cycle when the finished game beats the old best; drives
  // newHighScore one cycle later so it trails the final died pulse by two.
  logic new_hs_p1;

  // BCD increment with ripple carry across digits. Callers guarantee the
  // value is not already all-9s.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic          point_ok;     // point that actually changes the score
  logic [SW-1:0] score_inc;
  logic [2:0]    lives_grant;  // lives after any extra-life grant, before a hit

`ifdef SCORE_TRACKER_EXTRA_LIFE_EN
  logic ones_roll;
`endif

  always_comb begin
    point_ok    = point && (score != ALL9);
    score_inc   = bcd_inc(score);
    lives_grant = lives;
`ifdef SCORE_TRACKER_EXTRA_LIFE_EN
    ones_roll   = point_ok && (score[3:0] == 4'd9);
    if (ones_roll && (lives < LIVES_0)) begin
      lives_grant = lives + 3'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      score        <= '0;
      high_score   <= '0;
      lives        <= 3'd0;
      game_active  <= 1'b0;
      newHighScore <= 1'b0;
      died         <= 1'b0;
      new_hs_p1    <= 1'b0;
    end else begin
      died         <= 1'b0;
      new_hs_p1    <= 1'b0;
      newHighScore <= new_hs_p1;

      case (state)
        IDLE, OVER: begin
          if (game_start) begin
            state       <= PLAY;
            score       <= '0;
            lives       <= LIVES_0;
            game_active <= 1'b1;
          end
        end

        PLAY: begin
          if (game_start) begin
            // Abort and restart; no events, best score untouched.
            score <= '0;
            lives <= LIVES_0;
          end else begin
            if (point_ok) begin
              score <= score_inc;
            end
            if (hit) begin
              died  <= 1'b1;
              lives <= lives_grant - 3'd1;
              if (lives_grant == 3'd1) begin
                state       <= CHECK;
                game_active <= 1'b0;
              end
            end else begin
              lives <= lives_grant;
            end
          end
        end

        CHECK: begin
          // Packed BCD orders the same as an unsigned vector.
          if (score > high_score) begin
            high_score <= score;
            new_hs_p1  <= 1'b1;
          end
          state <= OVER;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Game-event bookkeeping stage that sits directly upstream of the face-display controller.
- Counts points in BCD and tracks remaining lives for one game at a time.
- Retains the session high score across games.
- Emits the one-cycle newHighScore and died event pulses that the face controller turns into happy or sad faces.

Parameters:
DIGITS, 2, number of BCD digits in score and high_score (1..4)
MAX_LIVES, 3, lives granted at game start (1..7)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
game_start  input  1  one-cycle pulse; starts or restarts a game
point  input  1  one-cycle pulse; score +1
hit  input  1  one-cycle pulse; lose one life
score  output  4*DIGITS  current game score, packed BCD, most significant digit on top
high_score  output  4*DIGITS  best score this session, packed BCD
lives  output  3  remaining lives, binary
game_active  output  1  high while in PLAY
newHighScore  output  1  one-cycle pulse; the game just ended with score > high_score
died  output  1  one-cycle pulse; a life was lost

Behaviour:
- Reset (rst=1 at a clock edge):
  - State = IDLE; score=0, high_score=0, lives=0.
  - game_active, newHighScore and died all 0.
  - Reset applies from any state and aborts any game in progress.
- All outputs are registered. Event pulses are high for exactly one cycle, one cycle after the causing input is sampled.
- States: IDLE, PLAY, CHECK, OVER.
- IDLE:
  - game_active=0.
  - game_start -> PLAY, score=0, lives=MAX_LIVES.
  - point and hit are ignored.
- PLAY:
  - game_active=1.
  - point: BCD increment with per-digit carry. The score saturates at all-9s; a point at saturation is ignored.
  - hit: lives decrements and died pulses.
    - If lives was 1, lives becomes 0 and the next state is CHECK.
  - point and hit in the same cycle: apply the point first, then the hit. Both take effect.
  - game_start in PLAY:
    - Aborts the game: score=0, lives=MAX_LIVES, stay in PLAY.
    - No pulses are generated and high_score is unchanged.
    - game_start has priority over point and hit in the same cycle.
- CHECK (exactly one cycle, game_active=0):
  - If score > high_score (packed-BCD magnitude compare, equivalent to an unsigned vector compare): high_score <= score and newHighScore pulses.
  - Equal scores do not count as a new high score.
  - Next state is OVER.
  - Inputs are ignored in this cycle.
- OVER:
  - game_active=0. score and lives hold their final values for display.
  - game_start -> PLAY (same initialisation as from IDLE). point and hit are ignored.
- Sequencing of pulses:
  - died for the final life and newHighScore are never in the same cycle; newHighScore follows died by 2 cycles.
  - The downstream face controller is busy showing the sad face at that time. Accepting that it may miss the pulse is a system-level decision; this block does not hold or stretch pulses.
- high_score is only ever written in CHECK, never mid-game.

Optional Feature:
- Macro: SCORE_TRACKER_EXTRA_LIFE_EN
- Defined:
  - A point that carries the ones digit from 9 to 0 grants +1 life, capped at MAX_LIVES.
  - A saturated (ignored) point grants no life.
  - If the same cycle also has a hit, the grant applies before the hit decrement. Lives stay unchanged net and died still pulses; the game cannot end in that cycle unless lives was already 1 and at the cap.
- Undefined: no extra lives, and the ones-digit carry has no side effect on lives.

Test Plan:
- Reset then game_start, 5 point pulses -> score=0x05, lives=3, game_active=1, no pulses.
- From score 0x09, point -> score=0x10. From 0x99, point -> score stays 0x99.
- 3 hit pulses with score 0x07 and high_score 0x00:
  - died pulses 3 times and lives goes 3,2,1,0.
  - newHighScore pulses 2 cycles after the last died; high_score=0x07; state OVER, game_active=0.
- Second game ending with score 0x07 (equal) -> no newHighScore, high_score stays 0x07. A third game ending with 0x12 -> newHighScore, high_score=0x12.
- Boundary inputs:
  - point and hit in the same cycle at score 0x03, lives 2 -> score=0x04, lives=1, died pulses.
  - game_start together with hit -> score=0, lives=3, no died.
- rst asserted mid-PLAY with high_score 0x12 -> all outputs 0 next cycle, state IDLE.
- With SCORE_TRACKER_EXTRA_LIFE_EN defined:
  - lives=2, score 0x09, point -> lives=3.
  - At lives=3, score 0x19, point -> lives stays 3.
